// File: rtl/key_generator.sv
// Candidate-key sequencer: steps a 24-bit trial key through KEY_LOWER..KEY_UPPER,
// one step per rising edge of start, with a finished pulse and a sticky terminated flag.
module key_generator #(
  parameter logic [23:0] KEY_LOWER = 24'h000000,
  parameter logic [23:0] KEY_UPPER = 24'h3FFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        finished,
  output logic        terminated,
  output logic [23:0] key
);

  typedef enum logic [1:0] {
    IDLE,
    ADVANCE,
    ACK,
    EXHAUSTED
  } state_t;

  state_t      state, state_d;
  logic        start_q;
  logic        rise;
  logic [23:0] key_d;
  logic        finished_d;
  logic        terminated_d;

  // start_q resets high so a start already asserted at reset release is not a request
  assign rise = start & ~start_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      start_q    <= 1'b1;
      key        <= KEY_LOWER;
      finished   <= 1'b0;
      terminated <= 1'b0;
    end else begin
      state      <= state_d;
      start_q    <= start;
      key        <= key_d;
      finished   <= finished_d;
      terminated <= terminated_d;
    end
  end

  always_comb begin
    state_d      = state;
    key_d        = key;
    finished_d   = finished;
    terminated_d = terminated;
    case (state)
      IDLE: begin
        // the >= test stops the key before it could wrap past KEY_UPPER
        if (rise) state_d = (key >= KEY_UPPER) ? EXHAUSTED : ADVANCE;
      end
      ADVANCE: begin
        key_d      = key + 24'd1;
        finished_d = 1'b1;
        state_d    = ACK;
      end
      ACK: begin
        finished_d = 1'b0;
        state_d    = IDLE;
      end
      EXHAUSTED: begin
        terminated_d = 1'b1;
        finished_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_generator.sv
// Bench for key_generator: a small range (0..2) and a top-of-range (FFFFFE..FFFFFF) instance.
module tb_key_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        fin_a, term_a, fin_b, term_b;
  logic [23:0] key_a, key_b;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_a[$];
  logic [23:0] obs_a[$];
  logic [23:0] exp_b[$];
  logic [23:0] obs_b[$];
  logic [23:0] o, e;

  always #5 clk = ~clk;

  key_generator #(.KEY_LOWER(24'h000000), .KEY_UPPER(24'h000002)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .finished(fin_a), .terminated(term_a), .key(key_a)
  );

  key_generator #(.KEY_LOWER(24'hFFFFFE), .KEY_UPPER(24'hFFFFFF)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .finished(fin_b), .terminated(term_b), .key(key_b)
  );

  // every finished pulse delivers one key to the scoreboard
  always @(negedge clk) begin
    if (fin_a === 1'b1) obs_a.push_back(key_a);
    if (fin_b === 1'b1) obs_b.push_back(key_b);
  end

  task automatic apply_reset(input logic s);
    start_a = s;
    start_b = s;
    reset   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_a.delete(); obs_a.delete();
    exp_b.delete(); obs_b.delete();
  endtask

  task automatic drive_a(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 start_a = bits[i];
    end
  endtask

  task automatic drive_b(input logic v);
    @(posedge clk); #1 start_b = v;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 start_a = ~start_a; start_b = ~start_b;
      @(negedge clk);
      checks++;
      if (key_a !== 24'h0 || fin_a !== 1'b0 || term_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_a: key=%h fin=%b term=%b, expected key=000000 fin=0 term=0", key_a, fin_a, term_a);
      end
      checks++;
      if (key_b !== 24'hFFFFFE || fin_b !== 1'b0 || term_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_b: key=%h fin=%b term=%b, expected key=fffffe fin=0 term=0", key_b, fin_b, term_b);
      end
    end
    apply_reset(1'b0);
  endtask

  task automatic test_stepping();
    apply_reset(1'b0);
    for (int k = 1; k <= 2; k++) begin
      exp_a.push_back(24'(k));
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (fin_a !== 1'b0 || key_a !== 24'(k - 1)) begin
        errors++;
        $display("FAIL step_edgeN: fin=%b key=%h, expected fin=0 key=%h", fin_a, key_a, 24'(k - 1));
      end
      @(negedge clk);
      checks++;
      if (fin_a !== 1'b1 || key_a !== 24'(k)) begin
        errors++;
        $display("FAIL step_edgeN1: fin=%b key=%h, expected fin=1 key=%h", fin_a, key_a, 24'(k));
      end
      @(negedge clk);
      checks++;
      if (fin_a !== 1'b0) begin
        errors++;
        $display("FAIL step_pulse_width: fin=%b, expected 0", fin_a);
      end
      repeat (12) @(posedge clk);
      #1 start_a = 1'b0;
      repeat (15) @(posedge clk);
    end
    // third request at key == KEY_UPPER exhausts the range
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (term_a !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_early: term=%b, expected 0", term_a);
    end
    @(negedge clk);
    checks++;
    if (term_a !== 1'b1 || key_a !== 24'h2 || fin_a !== 1'b0) begin
      errors++;
      $display("FAIL exhaust: term=%b key=%h fin=%b, expected term=1 key=000002 fin=0", term_a, key_a, fin_a);
    end
    repeat (5) @(posedge clk);
    #1 start_a = 1'b0;
    checks++;
    if (obs_a.size() != exp_a.size()) begin
      errors++;
      $display("FAIL step_pulses: got %0d pulses, expected %0d", obs_a.size(), exp_a.size());
    end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front(); e = exp_a.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL step_key: got %h, expected %h", o, e);
      end
    end
  endtask

  task automatic test_sticky();
    obs_a.delete();
    for (int i = 0; i < 2; i++) drive_a(8'b0000_0001, 8);
    @(negedge clk);
    checks++;
    if (key_a !== 24'h2 || term_a !== 1'b1 || fin_a !== 1'b0 || obs_a.size() != 0) begin
      errors++;
      $display("FAIL sticky: key=%h term=%b fin=%b pulses=%0d, expected key=000002 term=1 fin=0 pulses=0",
               key_a, term_a, fin_a, obs_a.size());
    end
    // reset mid-cycle must act without waiting for a clock edge
    @(posedge clk); #3 reset = 1'b0;
    #1;
    checks++;
    if (key_a !== 24'h0 || term_a !== 1'b0 || fin_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: key=%h term=%b fin=%b, expected key=000000 term=0 fin=0", key_a, term_a, fin_a);
    end
    apply_reset(1'b0);
  endtask

  task automatic test_back_to_back();
    apply_reset(1'b0);
    exp_a.push_back(24'h1);
    drive_a(8'b0000_0101, 4);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (key_a !== 24'h1) begin
      errors++;
      $display("FAIL close_rise_key: key=%h, expected 000001", key_a);
    end
    checks++;
    if (obs_a.size() != exp_a.size()) begin
      errors++;
      $display("FAIL close_rise_pulses: got %0d pulses, expected %0d", obs_a.size(), exp_a.size());
    end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front(); e = exp_a.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL close_rise_sb: got %h, expected %h", o, e);
      end
    end

    apply_reset(1'b0);
    exp_a.push_back(24'h1);
    exp_a.push_back(24'h2);
    drive_a(8'b0001_1001, 5);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (key_a !== 24'h2 || term_a !== 1'b0) begin
      errors++;
      $display("FAIL spaced_rise_key: key=%h term=%b, expected key=000002 term=0", key_a, term_a);
    end
    checks++;
    if (obs_a.size() != exp_a.size()) begin
      errors++;
      $display("FAIL spaced_rise_pulses: got %0d pulses, expected %0d", obs_a.size(), exp_a.size());
    end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front(); e = exp_a.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL spaced_rise_sb: got %h, expected %h", o, e);
      end
    end
  endtask

  task automatic test_held_start();
    apply_reset(1'b1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (key_a !== 24'h0 || obs_a.size() != 0) begin
      errors++;
      $display("FAIL held_start: key=%h pulses=%0d, expected key=000000 pulses=0", key_a, obs_a.size());
    end
    exp_a.push_back(24'h1);
    drive_a(8'b0000_0010, 2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (key_a !== 24'h1 || obs_a.size() != 1) begin
      errors++;
      $display("FAIL held_rerise: key=%h pulses=%0d, expected key=000001 pulses=1", key_a, obs_a.size());
    end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front(); e = exp_a.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL held_sb: got %h, expected %h", o, e);
      end
    end
    start_a = 1'b0;
  endtask

  task automatic test_range_edge();
    apply_reset(1'b0);
    @(negedge clk);
    checks++;
    if (key_b !== 24'hFFFFFE) begin
      errors++;
      $display("FAIL edge_initial: key=%h, expected fffffe", key_b);
    end
    exp_b.push_back(24'hFFFFFF);
    drive_b(1'b1);
    repeat (4) @(posedge clk);
    drive_b(1'b0);
    repeat (3) @(posedge clk);
    drive_b(1'b1);
    repeat (5) @(posedge clk);
    drive_b(1'b0);
    @(negedge clk);
    checks++;
    if (key_b !== 24'hFFFFFF || term_b !== 1'b1 || fin_b !== 1'b0) begin
      errors++;
      $display("FAIL edge_exhaust: key=%h term=%b fin=%b, expected key=ffffff term=1 fin=0", key_b, term_b, fin_b);
    end
    checks++;
    if (obs_b.size() != exp_b.size()) begin
      errors++;
      $display("FAIL edge_pulses: got %0d pulses, expected %0d", obs_b.size(), exp_b.size());
    end
    while (obs_b.size() > 0 && exp_b.size() > 0) begin
      o = obs_b.pop_front(); e = exp_b.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL edge_sb: got %h, expected %h", o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stepping();
    test_sticky();
    test_back_to_back();
    test_held_start();
    test_range_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
